// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the byte-stream memory loader.
// Build option: MEM_LOADER_VERIFY_EN adds a read-back VERIFY state.
package mem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD  = 4;
    localparam int unsigned WORD_BYTES_LOG2 = 2;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned BCNT_W          = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
`ifdef MEM_LOADER_VERIFY_EN
        ST_VERIFY  = 3'd3,
`endif
        ST_DONE    = 3'd4
    } loader_state_t;

endpackage

// File: rtl/mem_loader_word_assembler.sv
// Collects accepted bytes into a little-endian 32-bit word.
// The byte counter wraps on the 4th byte; data is kept until overwritten
// so the finished word stays on the write-data bus through WRITE/VERIFY.
module word_assembler
    import mem_loader_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_accept,
    input  logic [BYTE_W-1:0]    i_data,
    output logic [WORD_W-1:0]    o_word,
    output logic                 o_word_full_c
);

    logic [BCNT_W-1:0] r_bcnt;
    logic [WORD_W-1:0] r_word;

    assign o_word        = r_word;
    assign o_word_full_c = i_accept && (r_bcnt == BCNT_W'(BYTES_PER_WORD - 1));

    // Byte counter and right-shifting word register (first byte ends in [7:0])
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bcnt <= '0;
            r_word <= '0;
        end else begin
            if (i_clr) begin
                r_bcnt <= '0;
            end else if (i_accept) begin
                r_bcnt <= r_bcnt + BCNT_W'(1);
            end
            if (i_accept) begin
                r_word <= {i_data, r_word[WORD_W-1:BYTE_W]};
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Run-time program/data loader: byte stream in, 32-bit word writes out
// to the unified memory port starting at BASE_ADDR.
// Build option: MEM_LOADER_VERIFY_EN enables per-word read-back compare
// and the sticky error flag; otherwise error is tied low and rd unused.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned WORDS     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LW        = $clog2(WORDS) + 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic [LW-1:0] i_len,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte_data,
    output logic          o_byte_ready,
    output logic          o_we,
    output logic [31:0]   o_a,
    output logic [31:0]   o_wd,
    input  logic [31:0]   i_rd,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error
);

    loader_state_t r_state;
    loader_state_t w_state_nxt;

    logic [LW-1:0] r_len;
    logic [LW-1:0] r_word_cnt;
    logic [31:0]   r_a;
    logic [LW-1:0] w_len_clamp;
    logic          w_start_acc;
    logic          w_accept;
    logic          w_word_full;
    logic          w_last;
    logic          w_cnt_inc;
    logic          w_asm_clr;

    // Outputs decoded from the state register only
    assign o_byte_ready = (r_state == ST_COLLECT);
    assign o_we         = (r_state == ST_WRITE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_a          = r_a;

    assign w_start_acc = (r_state == ST_IDLE) && i_start;
    assign w_accept    = i_byte_valid && o_byte_ready;
    assign w_len_clamp = (i_len > LW'(WORDS)) ? LW'(WORDS) : i_len;
    assign w_last      = ((r_word_cnt + LW'(1)) == r_len);
    assign w_asm_clr   = (r_state == ST_WRITE) || w_start_acc;

    word_assembler u_asm (
        .i_clk         (i_clk),
        .i_rst_n       (i_reset_n),
        .i_clr         (w_asm_clr),
        .i_accept      (w_accept),
        .i_data        (i_byte_data),
        .o_word        (o_wd),
        .o_word_full_c (w_word_full)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and word-count advance
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_inc   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (w_len_clamp == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_word_full) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
`ifdef MEM_LOADER_VERIFY_EN
                w_state_nxt = ST_VERIFY;
`else
                w_cnt_inc   = 1'b1;
                w_state_nxt = w_last ? ST_DONE : ST_COLLECT;
`endif
            end
`ifdef MEM_LOADER_VERIFY_EN
            ST_VERIFY: begin
                w_cnt_inc   = 1'b1;
                w_state_nxt = w_last ? ST_DONE : ST_COLLECT;
            end
`endif
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Load length, word counter and write address
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_a        <= '0;
        end else begin
            if (w_start_acc) begin
                r_len      <= w_len_clamp;
                r_word_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_word_cnt <= r_word_cnt + LW'(1);
            end
            if ((r_state == ST_COLLECT) && w_word_full) begin
                r_a <= BASE_ADDR + (32'(r_word_cnt) << WORD_BYTES_LOG2);
            end
        end
    end

`ifdef MEM_LOADER_VERIFY_EN
    logic r_error;

    // Sticky read-back mismatch flag, cleared by an accepted start
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_error <= 1'b0;
        end else if (w_start_acc) begin
            r_error <= 1'b0;
        end else if ((r_state == ST_VERIFY) && (i_rd != o_wd)) begin
            r_error <= 1'b1;
        end
    end

    assign o_error = r_error;
`else
    logic w_rd_unused;

    assign w_rd_unused = ^i_rd;
    assign o_error     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader with a word-array memory model.
module tb_mem_loader;

    localparam int unsigned WORDS = 64;
    localparam int unsigned LW    = $clog2(WORDS) + 1;
`ifdef MEM_LOADER_VERIFY_EN
    localparam int WPC = 6;
`else
    localparam int WPC = 5;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len_i;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          we;
    logic [31:0]   a;
    logic [31:0]   wd;
    logic [31:0]   rd;
    logic          busy;
    logic          done;
    logic          error;

    logic [31:0] mem [0:WORDS-1];
    logic        bad_rd;
    logic        exp_err;
    logic [7:0]  src_q [$];
    logic [31:0] wa_q [$];
    logic [31:0] wd_q [$];
    int          checks;
    int          errors;

    mem_loader #(.WORDS(WORDS), .BASE_ADDR(32'h0)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_start      (start),
        .i_len        (len_i),
        .i_byte_valid (byte_valid),
        .i_byte_data  (byte_data),
        .o_byte_ready (byte_ready),
        .o_we         (we),
        .o_a          (a),
        .o_wd         (wd),
        .i_rd         (rd),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge
    assign rd = (bad_rd && (a[7:2] == 6'd0)) ? 32'hDEAD_BEEF : mem[a[7:2]];
    always @(posedge clk) if (we) mem[a[7:2]] <= wd;

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (we) begin
            wa_q.push_back(a);
            wd_q.push_back(wd);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a load of len words fed from src_q; mode 0 none, 1 alternate, 2 random stalls
    task automatic run_load(input string tag, input int len, input int mode);
        int eff, idx, cyc, done_cyc, br_seen;
        logic tog, v;
        logic [31:0] ew;
        eff = (len > int'(WORDS)) ? int'(WORDS) : len;
        wa_q.delete();
        wd_q.delete();
        @(posedge clk); #1;
        start = 1'b1;
        len_i = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        chk({tag, "_err_clr"}, {31'd0, error}, 32'd0);
        cyc = 1; idx = 0; done_cyc = -1; br_seen = 0; tog = 1'b0;
        while (cyc < 3000) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (byte_ready) br_seen++;
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            byte_valid = v;
            byte_data  = (idx < src_q.size()) ? src_q[idx] : 8'h00;
            if (v && byte_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        byte_valid = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, done_cyc >= 0}, 32'd1);
        if (mode == 0) chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(1 + WPC * eff));
        chk({tag, "_bytes"}, 32'(idx), 32'(4 * eff));
        chk({tag, "_nwr"}, 32'(wa_q.size()), 32'(eff));
        chk({tag, "_err_done"}, {31'd0, error}, {31'd0, exp_err});
        if (eff == 0) chk({tag, "_no_ready"}, 32'(br_seen), 32'd0);
        for (int i = 0; i < eff; i++) begin
            ew = {src_q[4*i+3], src_q[4*i+2], src_q[4*i+1], src_q[4*i]};
            if (i < wa_q.size()) begin
                chk({tag, "_addr"}, wa_q[i], 32'(4 * i));
                chk({tag, "_data"}, wd_q[i], ew);
            end
            chk({tag, "_mem"}, mem[i], ew);
        end
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    task automatic fill_rand(input int n);
        src_q.delete();
        for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
    endtask

    initial begin
        int idx;
        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; len_i = '0;
        byte_valid = 1'b0; byte_data = 8'h00;
        bad_rd = 1'b0; exp_err = 1'b0;
        for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {we, busy, done, error, byte_ready}, 32'd0);
        chk("rst_a", a, 32'd0);
        chk("rst_wd", wd, 32'd0);
        rst_n = 1'b1;

        src_q = '{8'h78, 8'h56, 8'h34, 8'h12};
        run_load("one_word", 1, 0);
        chk("one_word_val", wd_q.size() > 0 ? wd_q[0] : 32'hx, 32'h1234_5678);

        src_q.delete();
        for (int i = 0; i < 12; i++) src_q.push_back(8'(i));
        run_load("alt_stall", 3, 1);

        src_q.delete();
        run_load("len0", 0, 0);

        fill_rand(4 * (int'(WORDS) + 5));
        run_load("clamp", int'(WORDS) + 5, 0);
        chk("clamp_last_a", wa_q.size() > 0 ? wa_q[wa_q.size()-1] : 32'hx, 32'(4 * (WORDS - 1)));

        // Reset two bytes into word 1 of a 2-word load
        src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
        wa_q.delete(); wd_q.delete();
        @(posedge clk); #1;
        start = 1'b1; len_i = LW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        for (int c = 0; c < 7; c++) begin
            byte_valid = 1'b1;
            byte_data  = src_q[idx];
            if (byte_ready) idx++;
            @(posedge clk); #1;
        end
        chk("midrst_bytes", 32'(idx), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {we, busy, done, error, byte_ready}, 32'd0);
        chk("midrst_a", a, 32'd0);
        chk("midrst_wd", wd, 32'd0);
        chk("midrst_nwr", 32'(wa_q.size()), 32'd1);
        chk("midrst_mem0", mem[0], 32'hA3A2_A1A0);
        byte_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        src_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        run_load("reload", 1, 0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 6));
            fill_rand(4 * n);
            run_load("rand", n, (r == 0) ? 0 : 2);
        end

`ifdef MEM_LOADER_VERIFY_EN
        fill_rand(8);
        bad_rd = 1'b1; exp_err = 1'b1;
        run_load("vfy_bad", 2, 0);
        bad_rd = 1'b0; exp_err = 1'b0;
        fill_rand(4);
        run_load("vfy_clr", 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Program/data loader that is the writer side of the unified instruction/data memory port (`we`, `a`, `wd`, `rd`, word-aligned, combinational read, write on `clk` rising edge). It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them to consecutive word addresses from `BASE_ADDR`. The processor is held off the memory while `busy` is high, so images load at run time instead of from a fixed hex file.

## Interface
- `WORDS`, 64: memory depth in words; maximum load length.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first word; word-aligned, `[1:0]` = 0.
- `LW`, $clog2(WORDS)+1: width of `len`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state cleared while low.
- `start` in 1: sampled in IDLE only; begins a load of `len` words.
- `len` in LW: words to load, 0..WORDS, sampled with `start`.
- `byte_valid` in 1: source has a byte.
- `byte_data` in 8: byte payload.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `we` out 1: memory write enable.
- `a` out 32: memory byte address.
- `wd` out 32: memory write data.
- `rd` in 32: memory read data, used only for verify.
- `busy` out 1: load in progress; processor must not access memory.
- `done` out 1: one-cycle pulse at load end.
- `error` out 1: sticky verify mismatch; cleared by an accepted `start`.

## Operation
- States: IDLE, COLLECT, WRITE, VERIFY (only when verify is compiled in), DONE.
- IDLE: `byte_ready`=0, `busy`=0. On `start`:
  - latch `len`; clear word count, byte count and `error`.
  - go to COLLECT, or to DONE if `len`=0.
  - if `len`>WORDS, clamp to WORDS.
- COLLECT: `byte_ready`=1, `busy`=1.
  - A byte is accepted when `byte_valid & byte_ready` at a rising edge.
  - Byte k (k = 0..3) goes into `wd[8k+7:8k]`.
  - On the 4th accepted byte, go to WRITE. Byte count wraps to 0.
- WRITE: `we`=1 for exactly one cycle; `a` = BASE_ADDR + 4·word_count; `byte_ready`=0.
  - Next state is VERIFY if verify is compiled in.
  - Otherwise increment word_count, then go to DONE if word_count reaches `len`, else COLLECT.
- VERIFY: `we`=0, `a` and `wd` held.
  - If `rd`≠`wd`, set `error`.
  - Then increment word_count and go to DONE or COLLECT by the same rule.
- DONE: `done`=1 for one cycle, `busy`=1, then IDLE.
- `start` outside IDLE is ignored.
- `byte_valid` outside COLLECT is ignored, and no byte is consumed.
- Reset mid-load: returns to IDLE immediately. Words already written stay in memory; any partial word is discarded.

## Timing
- Reset values: `we`=0, `a`=0, `wd`=0, `byte_ready`=0, `busy`=0, `done`=0, `error`=0, state IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from `byte_valid` to any output.
- `start` at edge t gives `busy`=1 and `byte_ready`=1 from cycle t+1.
- With `byte_valid` held high:
  - 5 cycles per word (4 COLLECT + 1 WRITE), or 6 cycles per word with verify.
  - `done` pulses at cycle t+1+5·len, or t+1+6·len with verify.
- `len`=0: `done` at t+1, no write.
- `a` advances by 4 per word. The last address is BASE_ADDR+4·(len−1); it never exceeds BASE_ADDR+4·(WORDS−1).
- Stalls (`byte_valid`=0) hold state with no timeout.

## Configuration
- `MEM_LOADER_VERIFY_EN` defined:
  - VERIFY state exists; each written word is read back on the following cycle through `rd` and compared.
  - `error` is live.
- Not defined:
  - VERIFY state is removed and `rd` is unused.
  - `error` is tied to 0.
  - Throughput is 5 cycles per word.

## Structure
- Package `mem_loader_pkg` holds:
  - the state enum `loader_state_t`
  - `BYTES_PER_WORD`=4
  - `WORD_BYTES_LOG2`=2 (address increment shift)
- One sub-module, `word_assembler`:
  - byte counter plus 32-bit shift register; asserts `word_full` on the 4th accepted byte.
  - clear input is driven from WRITE.
- Top level keeps the FSM, word counter, address generation and verify compare.

## Test plan
- Reset, then `start`, `len`=1, bytes 0x78,0x56,0x34,0x12 back-to-back -> one `we` pulse, `a`=0x0, `wd`=0x12345678, `done` 5 cycles after `busy` rises.
- `len`=3, 12 bytes 0x00..0x0B with `byte_valid` low every other cycle -> writes 0x03020100@0x0, 0x07060504@0x4, 0x0B0A0908@0x8; no extra `we`.
- `len`=0 -> `done` one cycle after `start`, no `we`, `byte_ready` never 1.
- `len`=WORDS+5 -> exactly WORDS writes, last `a`=4·(WORDS−1), `done` follows.
- Reset pulled low after 2 bytes of word 1 of a 2-word load -> all outputs 0 immediately, word 0 retained in memory, a new `start` reloads from `a`=0x0.
- With `MEM_LOADER_VERIFY_EN`: memory model forces `rd`=0xDEADBEEF on word 0 -> `error`=1 after VERIFY, still set at `done`, cleared by the next `start`.
